// File: rtl/soup_reporter.sv
// Launches soup-search batches, tracks the all-time best step, and frames qualifying
// results as HDR, batch count, then the zero-padded capture, MSB byte first.
module soup_reporter #(
   parameter int          INIT     = 20,
   parameter int          MIN_STEP = 1000,
   parameter logic [7:0]  HDR      = 8'hA5
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic [31:0]            batch_size,
   output logic [31:0]            num_init,
   output logic                   run,
   input  logic                   life,
   input  logic [INIT*INIT+31:0]  life_data,
   output logic [7:0]             tx_data,
   output logic                   tx_valid,
   input  logic                   tx_ready,
   output logic [31:0]            best_step,
   output logic [31:0]            batch_count,
   output logic                   busy
);

   localparam int          DW    = INIT*INIT + 32;
   localparam int          NB    = (DW + 7) / 8;
   localparam int          F     = 1 + 4 + NB;
   localparam int          PW    = NB * 8;
   localparam int          IW    = $clog2(F);
   localparam logic [31:0] MIN_L = 32'(MIN_STEP);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT,
      S_EVAL,
      S_SEND
   } state_t;

   state_t            state, state_nxt;
   logic [DW-1:0]     cap;
   logic [IW-1:0]     idx;
   logic [31:0]       cap_step;
   logic [PW-1:0]     cap_pad;
   logic [F*8-1:0]    frame_vec;
   logic [7:0]        nxt_byte;
   logic              last_byte;
   logic              xfer;
   int                nxt_k;

   assign cap_step  = cap[DW-1 -: 32];
   assign cap_pad   = PW'(cap);
   assign frame_vec = {HDR, batch_count, cap_pad};
   assign last_byte = (idx == IW'(F-1));
   assign xfer      = tx_valid && tx_ready;
   assign run       = (state == S_LAUNCH);
   assign busy      = (state != S_IDLE);

   // Index of the byte that follows idx; clamped so the select never leaves the frame.
   always_comb begin
      nxt_k    = last_byte ? F-1 : int'(idx) + 1;
      nxt_byte = frame_vec[8*(F-1-nxt_k) +: 8];
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (enable) state_nxt = S_LAUNCH;
         S_LAUNCH: state_nxt = S_WAIT;
         S_WAIT:   if (life) state_nxt = S_EVAL;
         S_EVAL: begin
            if (cap_step >= MIN_L)  state_nxt = S_SEND;
            else if (enable)        state_nxt = S_LAUNCH;
            else                    state_nxt = S_IDLE;
         end
         S_SEND:   if (xfer && last_byte) state_nxt = enable ? S_LAUNCH : S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cap         <= '0;
         idx         <= '0;
         num_init    <= '0;
         best_step   <= '0;
         batch_count <= '0;
         tx_data     <= '0;
         tx_valid    <= 1'b0;
      end else begin
         case (state)
            S_LAUNCH: num_init <= batch_size;
            S_WAIT: begin
               if (life) begin
                  cap         <= life_data;
                  batch_count <= batch_count + 32'd1;
               end
            end
            S_EVAL: begin
               if (cap_step > best_step) best_step <= cap_step;
               if (cap_step >= MIN_L) begin
                  tx_valid <= 1'b1;
                  tx_data  <= HDR;
                  idx      <= '0;
               end
            end
            S_SEND: begin
               // Data advances only on a transfer, so a stalled byte holds.
               if (xfer) begin
                  if (last_byte) begin
                     tx_valid <= 1'b0;
                  end else begin
                     idx     <= idx + IW'(1);
                     tx_data <= nxt_byte;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
